energy_min_tracker: RTL

- Sequential stage directly downstream of the configurable two-operand comparator (instantiated once inside).
- Consumes a stream of per-iteration energy samples from the Ising solve loop and tracks the running minimum and the index at which it occurred.
- Reports the best sample once a programmed number of samples has been accepted.
- Feeds the result-readout logic.

---
 rtl/energy_pkg.sv | 13 +
 rtl/energy_min_tracker_cmp2.sv | 26 ++
 rtl/energy_min_tracker.sv | 108 ++++++++++
 3 files changed

// File: rtl/energy_pkg.sv
// Shared types and default sizes for the energy minimum tracker.
package energy_pkg;

    localparam int ENERGY_WIDTH = 16;
    localparam int SAMPLE_IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/energy_min_tracker_cmp2.sv
// Two-operand magnitude comparator (DW01_cmp2 behaviour, LT_LE output only).
// LEQ selects A <= B instead of A < B; TC selects two's-complement operands.
module DW01_cmp2 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             LEQ,
    input  logic             TC,
    output logic             LT_LE
);

    logic lt;
    logic eq;

    always_comb begin
        eq = (A == B);
        if (TC) begin
            lt = ($signed(A) < $signed(B));
        end else begin
            lt = (A < B);
        end
        LT_LE = lt | (LEQ & eq);
    end

endmodule

// File: rtl/energy_min_tracker.sv
// Running-minimum tracker over a programmed number of energy samples.
// Define ENERGY_MIN_TIE_LAST_EN to let equal samples replace the minimum (latest index wins).
module energy_min_tracker
    import energy_pkg::*;
#(
    parameter int WIDTH = ENERGY_WIDTH,
    parameter int IDX_W = SAMPLE_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] num_samples,
    input  logic             tc,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             min_valid,
    output logic [WIDTH-1:0] min_val,
    output logic [IDX_W-1:0] min_idx
);

`ifdef ENERGY_MIN_TIE_LAST_EN
    localparam logic TIE_LEQ = 1'b1;
`else
    localparam logic TIE_LEQ = 1'b0;
`endif

    state_t             state_reg;
    logic [IDX_W-1:0]   count_reg;
    logic [IDX_W-1:0]   num_reg;
    logic               tc_reg;
    logic               first_reg;
    logic               min_valid_reg;
    logic [WIDTH-1:0]   min_val_reg;
    logic [IDX_W-1:0]   min_idx_reg;
    logic               replace;

    DW01_cmp2 #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .A     (in_data),
        .B     (min_val_reg),
        .LEQ   (TIE_LEQ),
        .TC    (tc_reg),
        .LT_LE (replace)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            num_reg       <= '0;
            tc_reg        <= 1'b0;
            first_reg     <= 1'b0;
            min_valid_reg <= 1'b0;
            min_val_reg   <= '0;
            min_idx_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        min_valid_reg <= 1'b0;
                        if (num_samples != '0) begin
                            state_reg <= SCAN;
                            num_reg   <= num_samples;
                            tc_reg    <= tc;
                            count_reg <= '0;
                            first_reg <= 1'b1;
                        end else begin
                            state_reg <= DONE;
                        end
                    end
                end
                SCAN: begin
                    // in_ready is implied by being in SCAN
                    if (in_valid) begin
                        if (first_reg || replace) begin
                            min_val_reg <= in_data;
                            min_idx_reg <= count_reg;
                        end
                        first_reg <= 1'b0;
                        count_reg <= count_reg + IDX_W'(1);
                        if (count_reg == num_reg - IDX_W'(1)) begin
                            state_reg     <= DONE;
                            min_valid_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == SCAN);
    assign busy      = (state_reg == SCAN) || (state_reg == DONE);
    assign done      = (state_reg == DONE);
    assign min_valid = min_valid_reg;
    assign min_val   = min_val_reg;
    assign min_idx   = min_idx_reg;

endmodule
